// File: rtl/uart_tx_fifo_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo_cfg
//  Description : Configurable UART transmitter with a TX FIFO. Supports 5..9
//                data bits, runtime parity (none/even/odd) and 1 or 2 stop
//                bits, and sends queued words back-to-back with no idle gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo_cfg #(
  parameter int DATA_WIDTH  = 8,
  parameter int CLK_FREQ_HZ = 125_000_000,
  parameter int BAUDRATE    = 9600,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_stop2,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUDRATE;
  localparam int CNT_W        = $clog2(2 * CLKS_PER_BIT);
  localparam int BIT_W        = ($clog2(DATA_WIDTH) > 3) ? $clog2(DATA_WIDTH) : 3;
  localparam int ADDR_W       = $clog2(FIFO_DEPTH);
  localparam int COUNT_W      = ADDR_W + 1;

  localparam logic [CNT_W-1:0]   BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]   STOP2_LAST = CNT_W'(2 * CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]   DATA_LAST  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [COUNT_W-1:0] FULL_COUNT = COUNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // FIFO storage and pointers
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [COUNT_W-1:0]    count_next;
  logic                  push;
  logic                  pop;
  logic [DATA_WIDTH-1:0] head;

  // Transmitter state
  state_t                state;
  logic [CNT_W-1:0]      baud_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift;
  logic                  par_en;
  logic                  par_bit;
  logic                  stop2_q;
  logic [CNT_W-1:0]      stop_last;
  logic [CNT_W-1:0]      stop_pre;
  logic                  frame_end;

  assign push      = s_valid && s_ready;
  assign head      = mem[rd_ptr];
  assign stop_last = stop2_q ? STOP2_LAST : BIT_LAST;
  assign stop_pre  = stop_last - CNT_W'(1);
  assign frame_end = (state == STOP) && (baud_cnt == stop_last);
  // A word leaves the FIFO either from idle or on the last stop cycle,
  // so consecutive frames abut without an idle bit.
  assign pop       = (fifo_count != '0) && ((state == IDLE) || frame_end);

  // Occupancy after this cycle's push/pop; simultaneous push+pop cancels
  always_comb begin
    count_next = fifo_count;
    if (push && !pop) begin
      count_next = fifo_count + COUNT_W'(1);
    end else if (!push && pop) begin
      count_next = fifo_count - COUNT_W'(1);
    end
  end

  // FIFO write port; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // FIFO pointers, occupancy and registered ready (= not full next cycle)
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      s_ready    <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + ADDR_W'(1);
      fifo_count <= count_next;
      s_ready    <= (count_next != FULL_COUNT);
    end
  end

  // Frame sequencer with registered line, busy and done outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      stop2_q  <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
        end
        START: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            if (bit_cnt == DATA_LAST) begin
              if (par_en) begin
                tx    <= par_bit;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        PARITY: begin
          if (baud_cnt == BIT_LAST) begin
            baud_cnt <= '0;
            tx       <= 1'b1;
            state    <= STOP;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (baud_cnt == stop_pre) begin
            tx_done <= 1'b1;
          end
          if (frame_end) begin
            baud_cnt <= '0;
            tx_busy  <= 1'b0;
            state    <= IDLE;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: begin
          baud_cnt <= '0;
          tx       <= 1'b1;
          tx_busy  <= 1'b0;
          state    <= IDLE;
        end
      endcase
      // Loading a new word overrides the IDLE/STOP exit chosen above and
      // latches the frame format so later cfg changes affect the next frame.
      if (pop) begin
        shift    <= head;
        par_en   <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
        par_bit  <= (cfg_parity == 2'b10) ? ~^head : ^head;
        stop2_q  <= cfg_stop2;
        baud_cnt <= '0;
        bit_cnt  <= '0;
        tx       <= 1'b0;
        tx_busy  <= 1'b1;
        state    <= START;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo_cfg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo_cfg
//  Description : Directed bench for uart_tx_fifo_cfg at 10 clocks per bit,
//                with an 8-bit and a 5-bit instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo_cfg;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] cfg_parity = 2'b00;
  logic       cfg_stop2  = 1'b0;

  logic [7:0] s_data8  = '0;
  logic       s_valid8 = 1'b0;
  logic       s_ready8, tx8, busy8, done8;
  logic [4:0] count8;

  logic [4:0] s_data5  = '0;
  logic       s_valid5 = 1'b0;
  logic       s_ready5, tx5, busy5, done5;
  logic [4:0] count5;

  logic sel = 1'b0;
  logic m_tx, m_busy, m_done, m_ready;
  assign m_tx    = sel ? tx5      : tx8;
  assign m_busy  = sel ? busy5    : busy8;
  assign m_done  = sel ? done5    : done8;
  assign m_ready = sel ? s_ready5 : s_ready8;

  int checks = 0;
  int errors = 0;

  uart_tx_fifo_cfg #(.DATA_WIDTH(8), .CLK_FREQ_HZ(1_000_000), .BAUDRATE(100_000), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .s_data(s_data8), .s_valid(s_valid8), .s_ready(s_ready8),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .tx(tx8), .tx_busy(busy8),
    .tx_done(done8), .fifo_count(count8));

  uart_tx_fifo_cfg #(.DATA_WIDTH(5), .CLK_FREQ_HZ(1_000_000), .BAUDRATE(100_000), .FIFO_DEPTH(16)) dut5 (
    .clk(clk), .rst(rst), .s_data(s_data5), .s_valid(s_valid5), .s_ready(s_ready5),
    .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2), .tx(tx5), .tx_busy(busy5),
    .tx_done(done5), .fifo_count(count5));

  always #5 clk = ~clk;

  // One single-frame vector: line bits listed LSB = start bit, one entry per bit time
  typedef struct {
    logic       dw5;
    logic [7:0] data;
    logic [1:0] par;
    logic       stop2;
    int         nbits;
    logic [11:0] bits;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  function automatic logic frame_8n1(input logic [7:0] d, input int k);
    logic [9:0] fr;
    fr = {1'b1, d, 1'b0};
    return fr[k / CPB];
  endfunction

  task automatic run_vec(input vec_t v);
    int len, bad, dcnt, dpos, busy_bad;
    sel = v.dw5;
    len = v.nbits * CPB;
    @(negedge clk);
    cfg_parity = v.par;
    cfg_stop2  = v.stop2;
    if (v.dw5) begin s_data5 = v.data[4:0]; s_valid5 = 1'b1; end
    else       begin s_data8 = v.data;      s_valid8 = 1'b1; end
    chk("ready_before_push", m_ready, 1);
    @(posedge clk); #1;
    s_valid5 = 1'b0;
    s_valid8 = 1'b0;
    chk("tx_high_on_accept", m_tx, 1);
    bad = 0; dcnt = 0; dpos = -1; busy_bad = 0;
    for (int k = 0; k < len; k++) begin
      @(posedge clk); #1;
      if (m_tx !== v.bits[k / CPB]) bad++;
      if (m_done) begin dcnt++; dpos = k; end
      if (!m_busy) busy_bad++;
    end
    chk("frame_bad_cycles", bad, 0);
    chk("done_pulses", dcnt, 1);
    chk("done_position", dpos, len - 1);
    chk("busy_gaps", busy_bad, 0);
    @(posedge clk); #1;
    chk("idle_after_frame", {m_tx, m_busy, m_done}, 3'b100);
  endtask

  // Pushes three words on consecutive cycles; returns 1 cycle into frame 1
  task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    sel = 1'b0;
    cfg_parity = 2'b00;
    cfg_stop2  = 1'b0;
    @(negedge clk); s_data8 = a; s_valid8 = 1'b1;
    @(negedge clk); s_data8 = b;
    @(negedge clk); s_data8 = c;
    @(posedge clk); #1;
    s_valid8 = 1'b0;
  endtask

  initial begin
    int bad, dcnt, busy_bad, t;
    logic [7:0] words [3];
    logic [7:0] dec;
    logic got;

    //            dw5   data   par    stop2 nbits bits
    vecs[0] = '{1'b0, 8'h55, 2'b00, 1'b0, 10, 12'h2AA}; // 8N1
    vecs[1] = '{1'b0, 8'h07, 2'b01, 1'b1, 12, 12'hE0E}; // 8E2, parity 1
    vecs[2] = '{1'b0, 8'h07, 2'b10, 1'b0, 11, 12'h40E}; // 8O1, parity 0
    vecs[3] = '{1'b0, 8'hA1, 2'b11, 1'b0, 10, 12'h342}; // mode 11 = none
    vecs[4] = '{1'b0, 8'h80, 2'b10, 1'b0, 11, 12'h500}; // 8O1, parity 0
    vecs[5] = '{1'b1, 8'h1F, 2'b11, 1'b0,  7, 12'h07E}; // 5-bit, no parity

    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx", tx8, 1);
    chk("reset_busy", busy8, 0);
    chk("reset_done", done8, 0);
    chk("reset_ready", s_ready8, 1);
    chk("reset_count", count8, 0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);
    sel = 1'b0;

    // Three contiguous frames
    words[0] = 8'hA1; words[1] = 8'hB2; words[2] = 8'hC3;
    push3(words[0], words[1], words[2]);
    bad = 0; dcnt = 0; busy_bad = 0;
    for (int k = 1; k < 3 * 10 * CPB; k++) begin
      if (k > 1) begin @(posedge clk); #1; end
      if (tx8 !== frame_8n1(words[k / (10 * CPB)], k % (10 * CPB))) bad++;
      if (done8) begin
        dcnt++;
        if ((k % (10 * CPB)) != 10 * CPB - 1) bad++;
      end
      if (!busy8) busy_bad++;
    end
    chk("b2b_frame_bits", bad, 0);
    chk("b2b_done_pulses", dcnt, 3);
    chk("b2b_busy_gaps", busy_bad, 0);
    @(posedge clk); #1;
    chk("b2b_idle_after", {tx8, busy8, count8}, {1'b1, 1'b0, 5'd0});

    // Fill to full: one word in flight plus 16 queued, an 18th held
    cfg_parity = 2'b00; cfg_stop2 = 1'b0;
    for (int w = 0; w < 17; w++) begin
      @(negedge clk); s_data8 = 8'h10 + 8'(w); s_valid8 = 1'b1;
      @(posedge clk);
    end
    #1;
    s_data8 = 8'h21;
    chk("full_count", count8, 16);
    chk("full_ready_low", s_ready8, 0);
    got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(negedge clk);
      if (s_ready8) begin
        got = 1'b1;
        chk("drain_first_frame", count8, 15);
      end
    end
    chk("held_word_accepted", got, 1);
    @(posedge clk); #1;
    s_valid8 = 1'b0;
    chk("refill_count", count8, 16);
    chk("refill_ready_low", s_ready8, 0);
    got = 1'b0;
    for (int n = 0; n < 300 && !got; n++) begin
      @(posedge clk); #1;
      if (done8) got = 1'b1;
    end
    chk("second_done_seen", got, 1);
    dec = '0;
    for (int k = 0; k < 10 * CPB; k++) begin
      @(posedge clk); #1;
      if (k == 0) chk("drain_second_frame", count8, 15);
      if ((k % CPB) == 5 && (k / CPB) >= 1 && (k / CPB) <= 8) dec[(k / CPB) - 1] = tx8;
    end
    chk("fifo_order_word2", dec, 8'h12);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;

    // Reset in the data phase of frame 2 of 3
    push3(8'h3C, 8'h5A, 8'h96);
    repeat (10 * CPB + 3 * CPB - 1) @(posedge clk);
    #1;
    chk("pre_reset_count", count8, 1);
    chk("pre_reset_busy", busy8, 1);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_state", {tx8, busy8, done8, s_ready8, count8}, {1'b1, 1'b0, 1'b0, 1'b1, 5'd0});
    @(negedge clk); rst = 1'b0;
    t = 0;
    for (int k = 0; k < 30 * CPB; k++) begin
      @(posedge clk); #1;
      if (tx8 !== 1'b1 || busy8 || done8) t++;
    end
    chk("no_frames_after_reset", t, 0);
    chk("count_after_reset", count8, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
